// File: rtl/antares_load_store_unit_pkg.sv
// Shared definitions for the Antares load/store unit: FSM states and byte-lane select constants.
package antares_load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Big-endian lanes: byte offset 0 lives on [31:24].
  localparam logic [3:0] BSEL_NONE  = 4'b0000;
  localparam logic [3:0] BSEL_BYTE0 = 4'b1000;
  localparam logic [3:0] BSEL_HALF0 = 4'b1100;
  localparam logic [3:0] BSEL_HALF2 = 4'b0011;
  localparam logic [3:0] BSEL_WORD  = 4'b1111;

endpackage

// File: rtl/antares_memory_aligner.sv
// Combinational big-endian lane steering: store replication/byte-select and load extraction/extension.
module antares_memory_aligner
  import antares_load_store_unit_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic        byte_i,
  input  logic        half_i,
  input  logic        sign_ext_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] store_data_o,
  output logic [3:0]  byte_sel_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    store_data_o = store_data_i;
    byte_sel_o   = BSEL_WORD;
    load_data_o  = load_data_i;
    lane8        = '0;
    lane16       = '0;
    if (byte_i) begin
      byte_sel_o   = BSEL_BYTE0 >> offset_i;
      store_data_o = {4{store_data_i[7:0]}};
      case (offset_i)
        2'd0:    lane8 = load_data_i[31:24];
        2'd1:    lane8 = load_data_i[23:16];
        2'd2:    lane8 = load_data_i[15:8];
        default: lane8 = load_data_i[7:0];
      endcase
      load_data_o = {{24{sign_ext_i & lane8[7]}}, lane8};
    end else if (half_i) begin
      byte_sel_o   = offset_i[1] ? BSEL_HALF2 : BSEL_HALF0;
      store_data_o = {2{store_data_i[15:0]}};
      lane16       = offset_i[1] ? load_data_i[15:0] : load_data_i[31:16];
      load_data_o  = {{16{sign_ext_i & lane16[15]}}, lane16};
    end
  end

endmodule

// File: rtl/antares_load_store_unit.sv
// MEM-stage load/store unit: IDLE/REQ/DONE handshake to a 32-bit big-endian data port.
// Optional LL/SC link bit enabled by defining ANTARES_LLSC_EN.
module antares_load_store_unit
  import antares_load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_mem_store_data,
  input  logic        mem_mem_write,
  input  logic        mem_mem_to_gpr_select,
  input  logic        mem_mem_byte,
  input  logic        mem_mem_halfword,
  input  logic        mem_mem_data_sign_ext,
  input  logic        mem_llsc,
  input  logic        mem_kernel_mode,
  input  logic        mem_flush,
  input  logic        mem_hold,
  input  logic        ll_clear,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_byte_sel,
  output logic        dport_write,
  output logic        dport_enable,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready,
  input  logic        dport_error,
  output logic [31:0] mem_read_data,
  output logic        mem_request_stall,
  output logic        exc_address_error_load,
  output logic        exc_address_error_store,
  output logic        exc_bus_error
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  off_q, off_d;
  logic        write_q, write_d, byte_q, byte_d, half_q, half_d;
  logic        sext_q, sext_d, llsc_q, llsc_d;
  logic        discard_q, discard_d, buserr_q, buserr_d;

  logic        is_word, access, misaligned, user_viol, addr_err, sc_fail, valid_access;
  logic        in_idle, in_req, in_done;
  logic [1:0]  al_off;
  logic        al_byte, al_half, al_sext;
  logic [31:0] al_store_data, al_load_data;
  logic [3:0]  al_sel;

  assign in_idle    = (state_q == LSU_IDLE);
  assign in_req     = (state_q == LSU_REQ);
  assign in_done    = (state_q == LSU_DONE);

  assign is_word    = ~mem_mem_byte & ~mem_mem_halfword;
  assign access     = (mem_mem_to_gpr_select | mem_mem_write) & ~mem_flush;
  assign misaligned = (mem_mem_halfword & mem_alu_result[0]) | (is_word & (|mem_alu_result[1:0]));
  assign user_viol  = ~mem_kernel_mode & mem_alu_result[31];
  assign addr_err   = access & (misaligned | user_viol);

`ifdef ANTARES_LLSC_EN
  logic link_q, link_d;

  assign sc_fail = mem_mem_write & mem_llsc & ~link_q;

  always_comb begin
    link_d = link_q;
    if (in_req && dport_ready) begin
      if (write_q) begin
        link_d = 1'b0;
      end else if (llsc_q && !dport_error && !discard_d) begin
        link_d = 1'b1;
      end
    end
    if (ll_clear) begin
      link_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_q <= 1'b0;
    end else begin
      link_q <= link_d;
    end
  end
`else
  logic unused_ll_clear;

  assign sc_fail         = 1'b0;
  assign unused_ll_clear = ll_clear;
`endif

  assign valid_access = access & ~misaligned & ~user_viol & ~sc_fail;

  // One aligner serves both paths: live controls while issuing, latched controls while the load returns.
  assign al_off  = in_req ? off_q  : mem_alu_result[1:0];
  assign al_byte = in_req ? byte_q : mem_mem_byte;
  assign al_half = in_req ? half_q : mem_mem_halfword;
  assign al_sext = in_req ? sext_q : mem_mem_data_sign_ext;

  antares_memory_aligner u_aligner (
    .offset_i     (al_off),
    .byte_i       (al_byte),
    .half_i       (al_half),
    .sign_ext_i   (al_sext),
    .store_data_i (mem_mem_store_data),
    .load_data_i  (dport_data_i),
    .store_data_o (al_store_data),
    .byte_sel_o   (al_sel),
    .load_data_o  (al_load_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    off_d     = off_q;
    write_d   = write_q;
    byte_d    = byte_q;
    half_d    = half_q;
    sext_d    = sext_q;
    llsc_d    = llsc_q;
    discard_d = discard_q;
    result_d  = result_q;
    buserr_d  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (valid_access) begin
          state_d   = LSU_REQ;
          addr_d    = {mem_alu_result[31:2], 2'b00};
          wdata_d   = al_store_data;
          sel_d     = al_sel;
          off_d     = mem_alu_result[1:0];
          write_d   = mem_mem_write;
          byte_d    = mem_mem_byte;
          half_d    = mem_mem_halfword;
          sext_d    = mem_mem_data_sign_ext;
          llsc_d    = mem_llsc;
          discard_d = 1'b0;
        end
      end
      LSU_REQ: begin
        // A late flush cannot abort the bus cycle; it only marks the result as dead.
        if (mem_flush) begin
          discard_d = 1'b1;
        end
        if (dport_ready) begin
          state_d  = LSU_DONE;
          buserr_d = dport_error;
          if (dport_error) begin
            result_d = '0;
          end else if (!write_q) begin
            result_d = al_load_data;
          end else begin
            result_d = {31'b0, llsc_q};
          end
        end
      end
      LSU_DONE: begin
        if (!mem_hold) begin
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LSU_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= BSEL_NONE;
      off_q     <= '0;
      write_q   <= 1'b0;
      byte_q    <= 1'b0;
      half_q    <= 1'b0;
      sext_q    <= 1'b0;
      llsc_q    <= 1'b0;
      discard_q <= 1'b0;
      result_q  <= '0;
      buserr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      off_q     <= off_d;
      write_q   <= write_d;
      byte_q    <= byte_d;
      half_q    <= half_d;
      sext_q    <= sext_d;
      llsc_q    <= llsc_d;
      discard_q <= discard_d;
      result_q  <= result_d;
      buserr_q  <= buserr_d;
    end
  end

  assign dport_address           = addr_q;
  assign dport_data_o            = wdata_q;
  assign dport_byte_sel          = sel_q;
  assign dport_write             = write_q;
  assign dport_enable            = in_req;
  assign mem_read_data           = (in_done && !discard_q) ? result_q : '0;
  assign mem_request_stall       = ~rst & ((in_idle & valid_access) | in_req);
  assign exc_address_error_load  = ~rst & in_idle & addr_err & ~mem_mem_write;
  assign exc_address_error_store = ~rst & in_idle & addr_err & mem_mem_write;
  assign exc_bus_error           = ~rst & in_done & buserr_q & ~discard_q;

endmodule

// File: tb/tb_antares_load_store_unit.sv
// Self-checking bench for antares_load_store_unit: directed vectors plus randomized accesses vs. a byte-level model.
module tb_antares_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_alu_result, mem_mem_store_data;
  logic        mem_mem_write, mem_mem_to_gpr_select, mem_mem_byte, mem_mem_halfword;
  logic        mem_mem_data_sign_ext, mem_llsc, mem_kernel_mode, mem_flush, mem_hold, ll_clear;
  logic [31:0] dport_address, dport_data_o, dport_data_i, mem_read_data;
  logic [3:0]  dport_byte_sel;
  logic        dport_write, dport_enable, dport_ready, dport_error;
  logic        mem_request_stall, exc_address_error_load, exc_address_error_store, exc_bus_error;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned r_stall, r_req;
  logic        r_saw_req, r_stable, r_done, r_exc_l, r_exc_s, r_write, r_berr, r_berr2, r_stall2;
  logic [31:0] r_addr, r_data, r_rd, r_rd2;
  logic [3:0]  r_sel;

  always #5 clk = ~clk;

  antares_load_store_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .mem_alu_result          (mem_alu_result),
    .mem_mem_store_data      (mem_mem_store_data),
    .mem_mem_write           (mem_mem_write),
    .mem_mem_to_gpr_select   (mem_mem_to_gpr_select),
    .mem_mem_byte            (mem_mem_byte),
    .mem_mem_halfword        (mem_mem_halfword),
    .mem_mem_data_sign_ext   (mem_mem_data_sign_ext),
    .mem_llsc                (mem_llsc),
    .mem_kernel_mode         (mem_kernel_mode),
    .mem_flush               (mem_flush),
    .mem_hold                (mem_hold),
    .ll_clear                (ll_clear),
    .dport_address           (dport_address),
    .dport_data_o            (dport_data_o),
    .dport_byte_sel          (dport_byte_sel),
    .dport_write             (dport_write),
    .dport_enable            (dport_enable),
    .dport_data_i            (dport_data_i),
    .dport_ready             (dport_ready),
    .dport_error             (dport_error),
    .mem_read_data           (mem_read_data),
    .mem_request_stall       (mem_request_stall),
    .exc_address_error_load  (exc_address_error_load),
    .exc_address_error_store (exc_address_error_store),
    .exc_bus_error           (exc_bus_error)
  );

  // Reference model: memory bytes numbered big-endian, byte k of a word = bits [31-8k -: 8].
  function automatic logic [31:0] model_load(input logic [31:0] word, input int unsigned off,
                                             input int unsigned nbytes, input bit sx);
    logic [31:0] v, mask, sign;
    v = word >> (8 * (4 - nbytes - off));
    if (nbytes == 4) return v;
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    v    = v & mask;
    sign = 32'd1 << (8 * nbytes - 1);
    if (sx && ((v & sign) != 0)) v = v - (mask + 32'd1);
    return v;
  endfunction

  function automatic logic [3:0] model_sel(input int unsigned off, input int unsigned nbytes);
    int unsigned s;
    if (nbytes == 4) s = 15;
    else if (nbytes == 2) s = 3 << (2 - off);
    else s = 1 << (3 - off);
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] d, input int unsigned nbytes);
    if (nbytes == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (nbytes == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic clear_ops();
    mem_mem_write         = 1'b0;
    mem_mem_to_gpr_select = 1'b0;
    mem_mem_byte          = 1'b0;
    mem_mem_halfword      = 1'b0;
    mem_mem_data_sign_ext = 1'b0;
    mem_llsc              = 1'b0;
    mem_flush             = 1'b0;
    mem_hold              = 1'b0;
    mem_kernel_mode       = 1'b1;
  endtask

  // Presents one MEM instruction, plays the bus slave, and records what the DUT did into r_*.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] sdata, input bit ld, input bit st,
                            input bit b, input bit h, input bit sx, input bit llsc, input bit kern,
                            input int unsigned delay, input bit err, input logic [31:0] rdata,
                            input bit flush_req, input bit hold);
    @(negedge clk);
    mem_alu_result        = addr;
    mem_mem_store_data    = sdata;
    mem_mem_to_gpr_select = ld;
    mem_mem_write         = st;
    mem_mem_byte          = b;
    mem_mem_halfword      = h;
    mem_mem_data_sign_ext = sx;
    mem_llsc              = llsc;
    mem_kernel_mode       = kern;
    mem_hold              = hold;
    mem_flush             = 1'b0;
    r_stall = 0; r_req = 0; r_saw_req = 0; r_stable = 1; r_done = 0;
    r_exc_l = 0; r_exc_s = 0; r_berr = 0; r_berr2 = 0; r_stall2 = 0; r_rd = '0; r_rd2 = '0;
    r_addr = '0; r_data = '0; r_sel = '0; r_write = 0;
    for (int cyc = 0; cyc < 64 && !r_done; cyc++) begin
      dport_ready  = 1'b0;
      dport_error  = 1'b0;
      dport_data_i = 32'hDEAD_BEEF;
      #1;
      if (cyc == 0) begin
        r_exc_l = exc_address_error_load;
        r_exc_s = exc_address_error_store;
      end
      if (mem_request_stall) r_stall++;
      if (dport_enable) begin
        if (!r_saw_req) begin
          r_saw_req = 1; r_addr = dport_address; r_data = dport_data_o;
          r_sel = dport_byte_sel; r_write = dport_write;
        end else if ({dport_address, dport_data_o, dport_byte_sel, dport_write} !==
                     {r_addr, r_data, r_sel, r_write}) begin
          r_stable = 0;
        end
        r_req++;
        if (flush_req) mem_flush = 1'b1;
        if (r_req > delay) begin
          dport_ready  = 1'b1;
          dport_error  = err;
          dport_data_i = rdata;
        end
      end
      if (!mem_request_stall) begin
        r_done = 1;
        r_rd   = mem_read_data;
        r_berr = exc_bus_error;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!r_done) begin
      n_fail++;
      $display("FAIL access_timeout addr=%h: stall still %b after 64 cycles, required 0", addr, mem_request_stall);
    end
    if (hold && r_done) begin
      #1;
      r_berr2  = exc_bus_error;
      r_rd2    = mem_read_data;
      r_stall2 = mem_request_stall;
      mem_hold = 1'b0;
      @(negedge clk);
    end
    dport_ready = 1'b0;
    dport_error = 1'b0;
    clear_ops();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_ops();
    ll_clear = 1'b0; dport_ready = 1'b0; dport_error = 1'b0; dport_data_i = '0;
    mem_alu_result = 32'h0000_0006; mem_mem_store_data = '0;
    mem_mem_to_gpr_select = 1'b1;
    #2;
    n_tests++;
    if ({exc_address_error_load, exc_address_error_store, exc_bus_error, mem_request_stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_exc_stall: got %b required 0000", {exc_address_error_load, exc_address_error_store, exc_bus_error, mem_request_stall});
    end
    mem_alu_result = 32'h0000_0100;
    #1;
    n_tests++;
    if (mem_request_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall_valid: got %b required 0", mem_request_stall);
    end
    clear_ops();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({dport_enable, dport_write, dport_byte_sel, mem_read_data, mem_request_stall} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b wr=%b sel=%b rd=%h stall=%b required all 0",
               dport_enable, dport_write, dport_byte_sel, mem_read_data, mem_request_stall);
    end
  endtask

  task automatic test_vectors();
    run_access(32'h0000_1003, 32'h0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 32'h1122_3380, 0, 0);
    n_tests++;
    if (r_sel !== 4'b0001) begin n_fail++; $display("FAIL lb_sel: got %b required 0001", r_sel); end
    n_tests++;
    if (r_rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h required ffffff80", r_rd); end
    n_tests++;
    if (r_stall !== 2) begin n_fail++; $display("FAIL lb_stall: got %0d required 2", r_stall); end

    run_access(32'h0000_2002, 32'h0000_BEEF, 0, 1, 0, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_data, r_sel, r_write, r_addr} !== {32'hBEEF_BEEF, 4'b0011, 1'b1, 32'h0000_2000}) begin
      n_fail++;
      $display("FAIL sh_bus: data=%h sel=%b wr=%b addr=%h required beefbeef 0011 1 00002000", r_data, r_sel, r_write, r_addr);
    end
    n_tests++;
    if (r_rd !== 32'h0) begin n_fail++; $display("FAIL sh_result: got %h required 0", r_rd); end

    run_access(32'h0000_0006, 32'h0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_exc_l, r_exc_s, r_saw_req, r_stall != 0} !== 4'b1000) begin
      n_fail++; $display("FAIL lw_misaligned: excl=%b excs=%b req=%b stall=%0d required 1 0 0 0", r_exc_l, r_exc_s, r_saw_req, r_stall);
    end
    run_access(32'h8000_0000, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_exc_l, r_exc_s, r_saw_req, r_stall != 0} !== 4'b1000) begin
      n_fail++; $display("FAIL lw_user: excl=%b excs=%b req=%b stall=%0d required 1 0 0 0", r_exc_l, r_exc_s, r_saw_req, r_stall);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit ld, b, h, sx, kern, err, hold, mis, viol;
      int unsigned nbytes, off, delay;
      logic [31:0] addr, sd, rdata, exp_rd;
      ld = 1'($urandom_range(0, 1));
      nbytes = (32'd1 << $urandom_range(0, 2));
      b = (nbytes == 1); h = (nbytes == 2);
      sx = 1'($urandom_range(0, 1)); kern = ($urandom_range(0, 3) != 0);
      err = ($urandom_range(0, 7) == 0); hold = 1'($urandom_range(0, 1));
      delay = $urandom_range(0, 3);
      addr = $urandom; sd = $urandom; rdata = $urandom;
      if ($urandom_range(0, 5) != 0) addr = addr - (addr % nbytes);
      off  = addr % 4;
      mis  = (off % nbytes) != 0;
      viol = mis || (!kern && addr >= 32'h8000_0000);
      run_access(addr, sd, ld, !ld, b, h, sx, 0, kern, delay, err, rdata, 0, hold);
      n_tests++;
      if ({r_exc_l, r_exc_s} !== {viol && ld, viol && !ld}) begin
        n_fail++; $display("FAIL rnd%0d addr_exc: got %b%b required %b%b", i, r_exc_l, r_exc_s, viol && ld, viol && !ld);
      end
      n_tests++;
      if (r_saw_req !== !viol) begin
        n_fail++; $display("FAIL rnd%0d bus_req: got %b required %b", i, r_saw_req, !viol);
      end
      if (viol) begin
        n_tests++;
        if (r_stall !== 0) begin n_fail++; $display("FAIL rnd%0d exc_stall: got %0d required 0", i, r_stall); end
      end else begin
        exp_rd = (ld && !err) ? model_load(rdata, off, nbytes, sx) : 32'h0;
        n_tests++;
        if ({r_addr, r_sel, r_write, r_stable} !== {addr & 32'hFFFF_FFFC, model_sel(off, nbytes), !ld, 1'b1}) begin
          n_fail++;
          $display("FAIL rnd%0d bus: addr=%h sel=%b wr=%b stable=%b required %h %b %b 1",
                   i, r_addr, r_sel, r_write, r_stable, addr & 32'hFFFF_FFFC, model_sel(off, nbytes), !ld);
        end
        if (!ld) begin
          n_tests++;
          if (r_data !== model_store(sd, nbytes)) begin
            n_fail++; $display("FAIL rnd%0d wdata: got %h required %h", i, r_data, model_store(sd, nbytes));
          end
        end
        n_tests++;
        if (r_stall !== delay + 2) begin n_fail++; $display("FAIL rnd%0d stall: got %0d required %0d", i, r_stall, delay + 2); end
        n_tests++;
        if ({r_rd, r_berr} !== {exp_rd, err}) begin
          n_fail++; $display("FAIL rnd%0d result: rd=%h berr=%b required %h %b", i, r_rd, r_berr, exp_rd, err);
        end
        if (hold) begin
          n_tests++;
          if ({r_rd2, r_berr2, r_stall2} !== {exp_rd, 2'b00}) begin
            n_fail++; $display("FAIL rnd%0d held_done: rd=%h berr=%b stall=%b required %h 0 0", i, r_rd2, r_berr2, r_stall2, exp_rd);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    mem_alu_result = 32'h0000_0401; mem_mem_to_gpr_select = 1'b1; mem_flush = 1'b1;
    #1;
    n_tests++;
    if ({mem_request_stall, exc_address_error_load} !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle: stall=%b excl=%b required 0 0", mem_request_stall, exc_address_error_load);
    end
    @(negedge clk); #1;
    n_tests++;
    if (dport_enable !== 1'b0) begin n_fail++; $display("FAIL flush_idle_en: got %b required 0", dport_enable); end
    clear_ops();
    run_access(32'h0000_0200, 32'h0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 32'h1234_5678, 1, 0);
    n_tests++;
    if ({r_saw_req, r_stable, r_req == 3} !== 3'b111) begin
      n_fail++; $display("FAIL flush_req_bus: req=%b stable=%b cycles=%0d required 1 1 3", r_saw_req, r_stable, r_req);
    end
    n_tests++;
    if ({r_rd, r_berr} !== 33'd0) begin n_fail++; $display("FAIL flush_req_discard: rd=%h berr=%b required 0 0", r_rd, r_berr); end
  endtask

  task automatic test_bus_error();
    run_access(32'h0000_0300, 32'h0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0, 1);
    n_tests++;
    if ({r_berr, r_berr2, r_rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL bus_error_pulse: first=%b second=%b rd=%h required 1 0 0", r_berr, r_berr2, r_rd);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_alu_result = 32'h0000_0040; mem_mem_to_gpr_select = 1'b1;
    dport_ready = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (dport_enable !== 1'b1) begin n_fail++; $display("FAIL midreq_enter: en=%b required 1", dport_enable); end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({dport_enable, dport_write, dport_byte_sel, mem_request_stall, exc_address_error_load,
         exc_address_error_store, exc_bus_error} !== 10'd0) begin
      n_fail++; $display("FAIL midreq_reset: en=%b sel=%b stall=%b required 0", dport_enable, dport_byte_sel, mem_request_stall);
    end
    clear_ops();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({dport_enable, mem_read_data} !== 33'd0) begin
      n_fail++; $display("FAIL midreq_after: en=%b rd=%h required 0 0", dport_enable, mem_read_data);
    end
    run_access(32'h0000_0044, 32'h0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'hCAFE_F00D, 0, 0);
    n_tests++;
    if ({r_stall == 2, r_rd} !== {1'b1, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL midreq_resume: stall=%0d rd=%h required 2 cafef00d", r_stall, r_rd);
    end
  endtask

  task automatic test_llsc();
`ifdef ANTARES_LLSC_EN
    run_access(32'h0000_0100, 32'h0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h1234_5678, 0, 0);
    n_tests++;
    if (r_rd !== 32'h1234_5678) begin n_fail++; $display("FAIL ll_data: got %h required 12345678", r_rd); end
    @(negedge clk) ll_clear = 1'b1;
    @(negedge clk) ll_clear = 1'b0;
    run_access(32'h0000_0100, 32'h55, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_saw_req, r_stall != 0, r_rd} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL sc_cleared: req=%b stall=%0d rd=%h required 0 0 0", r_saw_req, r_stall, r_rd);
    end
    run_access(32'h0000_0100, 32'h0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 0);
    run_access(32'h0000_0100, 32'h66, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_saw_req, r_write, r_data, r_rd} !== {2'b11, 32'h66, 32'h1}) begin
      n_fail++; $display("FAIL sc_linked: req=%b wr=%b data=%h rd=%h required 1 1 66 1", r_saw_req, r_write, r_data, r_rd);
    end
    run_access(32'h0000_0100, 32'h77, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_saw_req, r_rd} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL sc_after_sc: req=%b rd=%h required 0 0", r_saw_req, r_rd);
    end
    run_access(32'h0000_0100, 32'h0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    run_access(32'h0000_0180, 32'h1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0);
    run_access(32'h0000_0100, 32'h88, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_saw_req, r_rd} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL sc_after_sw: req=%b rd=%h required 0 0", r_saw_req, r_rd);
    end
`else
    run_access(32'h0000_0100, 32'h0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h1234_5678, 0, 0);
    n_tests++;
    if (r_rd !== 32'h1234_5678) begin n_fail++; $display("FAIL ll_as_lw: got %h required 12345678", r_rd); end
    @(negedge clk) ll_clear = 1'b1;
    @(negedge clk) ll_clear = 1'b0;
    run_access(32'h0000_0100, 32'h66, 0, 1, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 0);
    n_tests++;
    if ({r_saw_req, r_write, r_data, r_rd} !== {2'b11, 32'h66, 32'h1}) begin
      n_fail++; $display("FAIL sc_as_sw: req=%b wr=%b data=%h rd=%h required 1 1 66 1", r_saw_req, r_write, r_data, r_rd);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_flush();
    test_bus_error();
    test_reset_mid_req();
    test_llsc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
